// File: rtl/tern_pkg.sv
// Shared trit codes, FSM state type and trit width for the ternary adder.
// Trit code 11 is treated as zero wherever it is consumed.
package tern_pkg;

  localparam int TW = 2;

  localparam logic [TW-1:0] T0   = 2'b00;
  localparam logic [TW-1:0] T1   = 2'b01;
  localparam logic [TW-1:0] T2   = 2'b10;
  localparam logic [TW-1:0] TINV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  function automatic logic [TW-1:0] trit_val(
    input logic [TW-1:0] t
  );
    return (t == TINV) ? T0 : t;
  endfunction

endpackage

// File: rtl/tern_digit_add.sv
// Combinational one-trit adder with generate/propagate outputs.
// gen: a+b alone carries; prop: a+b carries only with a carry-in.
module tern_digit_add
  import tern_pkg::*;
(
  input  logic [TW-1:0] i_a,
  input  logic [TW-1:0] i_b,
  input  logic          i_cin,
  output logic [TW-1:0] o_sum,
  output logic          o_carry,
  output logic          o_gen,
  output logic          o_prop
);

  logic [2:0] w_ab;
  logic [2:0] w_s;
  logic [2:0] w_sm3;

  assign w_ab    = {1'b0, trit_val(i_a)}
                 + {1'b0, trit_val(i_b)};
  assign w_s     = w_ab + {2'b00, i_cin};
  assign w_sm3   = w_s - 3'd3;
  assign o_carry = (w_s >= 3'd3);
  assign o_sum   = o_carry ? w_sm3[1:0] : w_s[1:0];
  assign o_gen   = (w_ab >= 3'd3);
  assign o_prop  = (w_ab == 3'd2);

endmodule

// File: rtl/tern_seq_adder.sv
// Sequential ternary adder, GROUP trits per cycle over NTRITS/GROUP cycles.
// Optional invalid-code flag output enabled by TERN_ADD_ERRCHK_EN.
module tern_seq_adder
  import tern_pkg::*;
#(
  parameter int NTRITS = 8,
  parameter int GROUP  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TW*NTRITS-1:0] a,
  input  logic [TW*NTRITS-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TW*NTRITS-1:0] sum,
  output logic                 cout
`ifdef TERN_ADD_ERRCHK_EN
  ,
  output logic                 err
`endif
);

  localparam int NG = NTRITS / GROUP;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int GB = TW * GROUP;
  localparam logic [GW-1:0] G_LAST = GW'(NG - 1);

  state_t               r_state;
  logic [TW*NTRITS-1:0] r_a;
  logic [TW*NTRITS-1:0] r_b;
  logic                 r_c;
  logic [GW-1:0]        r_g;

  logic [GROUP:0]   w_c;
  logic [GB-1:0]    w_gsum;
  logic [GROUP-1:0] w_gen;
  logic [GROUP-1:0] w_prop;
  logic             w_la;

  assign in_ready  = (r_state == S_IDLE) & ~rst;
  assign out_valid = (r_state == S_DONE);
  assign w_c[0]    = r_c;

  // Operands shift down each cycle so the active group is always bits [GB-1:0].
  for (genvar j = 0; j < GROUP; j++) begin : g_dig
    tern_digit_add u_dig (
      .i_a    (r_a[j*TW +: TW]),
      .i_b    (r_b[j*TW +: TW]),
      .i_cin  (w_c[j]),
      .o_sum  (w_gsum[j*TW +: TW]),
      .o_carry(w_c[j+1]),
      .o_gen  (w_gen[j]),
      .o_prop (w_prop[j])
    );
  end

  // Lookahead copy of the group carry feeds the carry flop directly.
  always_comb begin
    w_la = r_c;
    for (int j = 0; j < GROUP; j++) begin
      w_la = w_gen[j] | (w_prop[j] & w_la);
    end
  end

`ifdef TERN_ADD_ERRCHK_EN
  logic w_inv;

  always_comb begin
    w_inv = 1'b0;
    for (int i = 0; i < NTRITS; i++) begin
      if (a[i*TW +: TW] == TINV) w_inv = 1'b1;
      if (b[i*TW +: TW] == TINV) w_inv = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_g     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef TERN_ADD_ERRCHK_EN
      err     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_g     <= '0;
            r_state <= S_CALC;
`ifdef TERN_ADD_ERRCHK_EN
            err     <= w_inv;
`endif
          end
        end
        S_CALC: begin
          for (int k = 0; k < NG; k++) begin
            if (r_g == GW'(k)) sum[k*GB +: GB] <= w_gsum;
          end
          r_a <= r_a >> GB;
          r_b <= r_b >> GB;
          r_c <= w_la;
          r_g <= r_g + 1'b1;
          if (r_g == G_LAST) begin
            cout    <= w_c[GROUP];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tern_seq_adder.sv
// Scoreboard bench for tern_seq_adder (NTRITS=8, GROUP=2).
// Checks err as well when built with TERN_ADD_ERRCHK_EN.
module tb_tern_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef TERN_ADD_ERRCHK_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        e;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  tern_seq_adder #(.NTRITS(8), .GROUP(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef TERN_ADD_ERRCHK_EN
    ,
    .err      (err)
`endif
  );

  function automatic logic [15:0] tpack(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[2*i +: 2] = 2'(x % 3);
      x = x / 3;
    end
    return r;
  endfunction

  function automatic int tval(input logic [15:0] p);
    int v;
    int w;
    v = 0;
    w = 1;
    for (int i = 0; i < 8; i++) begin
      if (p[2*i +: 2] != 2'b11) v += int'(p[2*i +: 2]) * w;
      w = w * 3;
    end
    return v;
  endfunction

  function automatic logic has_inv(input logic [15:0] p);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (p[2*i +: 2] == 2'b11) r = 1'b1;
    end
    return r;
  endfunction

  function automatic exp_t model(
    input logic [15:0] ma,
    input logic [15:0] mb,
    input logic        mc
  );
    exp_t r;
    int t;
    t = tval(ma) + tval(mb) + int'(mc);
    r.c = (t >= 6561);
    if (r.c) t = t - 6561;
    r.s = tpack(t);
    r.e = has_inv(ma) | has_inv(mb);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait got %b want 1", in_ready);
    end
  endtask

  task automatic accept(
    input logic [15:0] ta,
    input logic [15:0] tb,
    input logic        tc,
    input exp_t        e
  );
    wait_ready();
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    sb.push_back(e);
    tick();
    // Noise during CALC must be ignored.
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string nm);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    if ({sum, cout} !== {e.s, e.c}) begin
      errors++;
      $display("FAIL %s sum=%h cout=%b want sum=%h cout=%b",
               nm, sum, cout, e.s, e.c);
    end
`ifdef TERN_ADD_ERRCHK_EN
    checks++;
    if (err !== e.e) begin
      errors++;
      $display("FAIL %s_err got %b want %b", nm, err, e.e);
    end
`endif
  endtask

  task automatic run_txn(
    input string       nm,
    input logic [15:0] ta,
    input logic [15:0] tb,
    input logic        tc,
    input exp_t        e
  );
    int n;
    accept(ta, tb, tc, e);
    wait_done(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL %s_latency got %0d want 4", nm, n);
    end
    check_out(nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, cout, sum} !== 19'd0) begin
      errors++;
      $display("FAIL reset rdy=%b vld=%b cout=%b sum=%h want 0",
               in_ready, out_valid, cout, sum);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    exp_t e;
    e = '{s: 16'h0000, c: 1'b0, e: 1'b0};
    run_txn("zero", 16'h0000, 16'h0000, 1'b0, e);
    e = '{s: 16'h0000, c: 1'b1, e: 1'b0};
    run_txn("ripple", 16'hAAAA, 16'h0001, 1'b0, e);
    e = '{s: 16'h0015, c: 1'b0, e: 1'b0};
    run_txn("mixed", 16'h0006, 16'h0009, 1'b1, e);
    e = '{s: 16'hAAAA, c: 1'b1, e: 1'b0};
    run_txn("max", 16'hAAAA, 16'hAAAA, 1'b1, e);
  endtask

  task automatic test_random();
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      run_txn("random", ra, rb, rc, model(ra, rb, rc));
    end
  endtask

  task automatic test_hold();
    int n;
    exp_t e;
    e = model(16'h2961, 16'h1A48, 1'b1);
    accept(16'h2961, 16'h1A48, 1'b1, e);
    wait_done(n);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {sum, cout} !== {e.s, e.c}) begin
        errors++;
        $display("FAIL hold vld=%b rdy=%b sum=%h cout=%b want 1 0 %h %b",
                 out_valid, in_ready, sum, cout, e.s, e.c);
      end
    end
    in_valid = 1'b0;
    check_out("hold_out");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    bit seen;
    wait_ready();
    a = tpack(100);
    b = tpack(200);
    cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_rdy got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL abort_state vld=%b sum=%h cout=%b want 0",
               out_valid, sum, cout);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_release rdy=%b want 1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_out out_valid seen=1 want 0");
    end
    e = '{s: 16'h0002, c: 1'b0, e: 1'b0};
    run_txn("after_abort", 16'h0001, 16'h0001, 1'b0, e);
  endtask

  task automatic test_invalid_code();
    exp_t e;
    e = '{s: 16'h0001, c: 1'b0, e: 1'b1};
    run_txn("inv_code", 16'h0003, 16'h0001, 1'b0, e);
    e = '{s: 16'h0002, c: 1'b0, e: 1'b0};
    run_txn("clean_next", 16'h0001, 16'h0001, 1'b0, e);
    e = model(16'hC0F2, 16'h3A01, 1'b1);
    run_txn("inv_mix", 16'hC0F2, 16'h3A01, 1'b1, e);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra;
    for (int i = 0; i < 4; i++) begin
      ra = tpack(int'($urandom_range(0, 6560)));
      run_txn("b2b", ra, 16'hAAAA, 1'b1, model(ra, 16'hAAAA, 1'b1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_hold();
    test_abort();
    test_invalid_code();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
